// File: rtl/edge_period_meter_if.sv
// Signal bundle between edge_period_meter (master) and its consumer (slave).
// With PHASE_MEAS_EN defined, the ref_in / phase_cyc pair is added.
interface edge_period_meter_if #(
    parameter int COUNT_W = 16
);
    logic               sig_in;
    logic [COUNT_W-1:0] period_avg;
    logic [COUNT_W-1:0] high_avg;
    logic               meas_valid;
    logic               locked;
    logic               nosig;
`ifdef PHASE_MEAS_EN
    logic               ref_in;
    logic [COUNT_W-1:0] phase_cyc;

    modport master (
        input  sig_in, ref_in,
        output period_avg, high_avg, meas_valid, locked, nosig, phase_cyc
    );
    modport slave (
        output sig_in, ref_in,
        input  period_avg, high_avg, meas_valid, locked, nosig, phase_cyc
    );
`else
    modport master (
        input  sig_in,
        output period_avg, high_avg, meas_valid, locked, nosig
    );
    modport slave (
        output sig_in,
        input  period_avg, high_avg, meas_valid, locked, nosig
    );
`endif
endinterface

// File: rtl/edge_period_meter.sv
// Measures period and high time of sig_in in clk_50 cycles, averaged over 2^AVG_LOG2 periods.
// Define PHASE_MEAS_EN to add the ref_in -> sig_in rise delay measurement (phase_cyc).
//
// state      | meaning
// WAIT_FIRST | after reset; waiting for the origin rise, timeout counter running
// MEASURE    | counting periods / high time and accumulating samples
// NOSIG      | signal lost; next rise becomes a new timing origin
module edge_period_meter #(
    parameter int COUNT_W  = 16,
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 2000
) (
    input  logic                clk_50,
    input  logic                rst,
    edge_period_meter_if.master mif
);

    localparam int ACC_W = COUNT_W + AVG_LOG2;
    localparam int SMP_W = AVG_LOG2 + 1;
    localparam logic [SMP_W-1:0]   SMP_FULL = SMP_W'(1 << AVG_LOG2);
    localparam logic [COUNT_W-1:0] CNT_ONE  = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] TMO      = COUNT_W'(TIMEOUT);
    localparam logic [COUNT_W-1:0] TMO_M1   = COUNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        MEASURE    = 2'd1,
        NOSIG      = 2'd2
    } state_t;

    logic s_meta_q, s_q, s_dly_q;
    logic rise;

    always_ff @(posedge clk_50) begin
        if (rst) begin
            s_meta_q <= 1'b0;
            s_q      <= 1'b0;
            s_dly_q  <= 1'b0;
        end else begin
            s_meta_q <= mif.sig_in;
            s_q      <= s_meta_q;
            s_dly_q  <= s_q;
        end
    end

    assign rise = s_q & ~s_dly_q;

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [COUNT_W-1:0] period_cnt_q, period_cnt_d;
    logic [COUNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [ACC_W-1:0]   acc_p_q, acc_p_d;
    logic [ACC_W-1:0]   acc_h_q, acc_h_d;
    logic [SMP_W-1:0]   smp_cnt_q, smp_cnt_d;
    logic [COUNT_W-1:0] period_avg_q, period_avg_d;
    logic [COUNT_W-1:0] high_avg_q, high_avg_d;
    logic               meas_valid_q, meas_valid_d;
    logic               locked_q, locked_d;
    logic               nosig_q, nosig_d;
    logic [ACC_W-1:0]   acc_p_base, acc_h_base;
    logic [SMP_W-1:0]   smp_base;

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        acc_p_d      = acc_p_q;
        acc_h_d      = acc_h_q;
        smp_cnt_d    = smp_cnt_q;
        period_avg_d = period_avg_q;
        high_avg_d   = high_avg_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        nosig_d      = nosig_q;
        acc_p_base   = acc_p_q;
        acc_h_base   = acc_h_q;
        smp_base     = smp_cnt_q;

        case (state_q)
            WAIT_FIRST, NOSIG: begin
                // The origin rise only starts timing; counters start at 1 to cover the edge cycle.
                if (rise) begin
                    state_d      = MEASURE;
                    wait_cnt_d   = '0;
                    period_cnt_d = CNT_ONE;
                    high_cnt_d   = CNT_ONE;
                    acc_p_d      = '0;
                    acc_h_d      = '0;
                    smp_cnt_d    = '0;
                end else if (state_q == WAIT_FIRST) begin
                    if (wait_cnt_q >= TMO_M1) begin
                        state_d = NOSIG;
                        nosig_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
            end

            MEASURE: begin
                if (period_cnt_q != '1) period_cnt_d = period_cnt_q + 1'b1;
                if (s_q && (high_cnt_q != '1)) high_cnt_d = high_cnt_q + 1'b1;

                if (smp_cnt_q == SMP_FULL) begin
                    period_avg_d = COUNT_W'(acc_p_q >> AVG_LOG2);
                    high_avg_d   = COUNT_W'(acc_h_q >> AVG_LOG2);
                    meas_valid_d = 1'b1;
                    locked_d     = 1'b1;
                    nosig_d      = 1'b0;
                    acc_p_base   = '0;
                    acc_h_base   = '0;
                    smp_base     = '0;
                end

                acc_p_d   = acc_p_base;
                acc_h_d   = acc_h_base;
                smp_cnt_d = smp_base;

                // A rise in the result cycle lands on the freshly cleared sums, so no period is lost.
                if (rise) begin
                    acc_p_d      = acc_p_base + ACC_W'(period_cnt_q);
                    acc_h_d      = acc_h_base + ACC_W'(high_cnt_q);
                    smp_cnt_d    = smp_base + 1'b1;
                    period_cnt_d = CNT_ONE;
                    high_cnt_d   = CNT_ONE;
                end else if (period_cnt_q >= TMO) begin
                    state_d   = NOSIG;
                    nosig_d   = 1'b1;
                    locked_d  = 1'b0;
                    acc_p_d   = '0;
                    acc_h_d   = '0;
                    smp_cnt_d = '0;
                end
            end

            default: state_d = WAIT_FIRST;
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            state_q      <= WAIT_FIRST;
            wait_cnt_q   <= '0;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            acc_p_q      <= '0;
            acc_h_q      <= '0;
            smp_cnt_q    <= '0;
            period_avg_q <= '0;
            high_avg_q   <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            nosig_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            acc_p_q      <= acc_p_d;
            acc_h_q      <= acc_h_d;
            smp_cnt_q    <= smp_cnt_d;
            period_avg_q <= period_avg_d;
            high_avg_q   <= high_avg_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            nosig_q      <= nosig_d;
        end
    end

    assign mif.period_avg = period_avg_q;
    assign mif.high_avg   = high_avg_q;
    assign mif.meas_valid = meas_valid_q;
    assign mif.locked     = locked_q;
    assign mif.nosig      = nosig_q;

`ifdef PHASE_MEAS_EN
    logic               r_meta_q, r_q, r_dly_q;
    logic               ref_rise;
    logic               phase_armed_q, phase_armed_d;
    logic [COUNT_W-1:0] phase_cnt_q, phase_cnt_d;
    logic [COUNT_W-1:0] phase_cyc_q, phase_cyc_d;

    always_ff @(posedge clk_50) begin
        if (rst) begin
            r_meta_q <= 1'b0;
            r_q      <= 1'b0;
            r_dly_q  <= 1'b0;
        end else begin
            r_meta_q <= mif.ref_in;
            r_q      <= r_meta_q;
            r_dly_q  <= r_q;
        end
    end

    assign ref_rise = r_q & ~r_dly_q;

    always_comb begin
        phase_armed_d = phase_armed_q;
        phase_cnt_d   = phase_cnt_q;
        phase_cyc_d   = phase_cyc_q;
        if (phase_armed_q && (phase_cnt_q != '1)) phase_cnt_d = phase_cnt_q + 1'b1;

        // The latched value includes the sig edge cycle, so a lead of N cycles reads N.
        if (ref_rise) begin
            phase_cnt_d   = '0;
            phase_armed_d = ~rise;
            if (rise) phase_cyc_d = '0;
        end else if (rise && phase_armed_q) begin
            phase_cyc_d   = (phase_cnt_q == '1) ? phase_cnt_q : phase_cnt_q + 1'b1;
            phase_armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            phase_armed_q <= 1'b0;
            phase_cnt_q   <= '0;
            phase_cyc_q   <= '0;
        end else begin
            phase_armed_q <= phase_armed_d;
            phase_cnt_q   <= phase_cnt_d;
            phase_cyc_q   <= phase_cyc_d;
        end
    end

    assign mif.phase_cyc = phase_cyc_q;
`endif

endmodule

// File: tb/tb_edge_period_meter.sv
// Directed self-checking bench for edge_period_meter; inputs change on the falling edge,
// outputs are read on the falling edge. Phase trials run only when PHASE_MEAS_EN is defined.
module tb_edge_period_meter;

    localparam int COUNT_W  = 16;
    localparam int AVG_LOG2 = 2;
    localparam int TIMEOUT  = 2000;

    logic clk_50 = 1'b0;
    logic rst;

    edge_period_meter_if #(.COUNT_W(COUNT_W)) mif ();

    edge_period_meter #(
        .COUNT_W (COUNT_W),
        .AVG_LOG2(AVG_LOG2),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_50(clk_50),
        .rst   (rst),
        .mif   (mif)
    );

    always #10 clk_50 = ~clk_50;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int mv_total = 0;
    int mv_last = 0;
    int mv_prev = 0;

    always @(posedge clk_50) begin
        #1;
        cyc++;
        if (mif.meas_valid) begin
            mv_total++;
            mv_prev = mv_last;
            mv_last = cyc;
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_mis++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One period starting with a rise; reports the first meas_valid seen (negedges after the rise drive).
    task automatic drive_period(input int p, input int h, output int mv_at,
                                output int pa, output int ha, output int lk, output int ns);
        mv_at = -1; pa = -1; ha = -1; lk = -1; ns = -1;
        for (int i = 0; i < p; i++) begin
            mif.sig_in = (i < h);
            @(negedge clk_50);
            if (mif.meas_valid && (mv_at < 0)) begin
                mv_at = i + 1;
                pa = int'(mif.period_avg);
                ha = int'(mif.high_avg);
                lk = int'(mif.locked);
                ns = int'(mif.nosig);
            end
        end
    endtask

    // Origin rise plus four accumulated periods; results come from the period after the 5th rise.
    task automatic lock_up(input int p, input int h, output int mv_at,
                           output int pa, output int ha, output int lk, output int ns);
        int d0, d1, d2, d3, d4;
        for (int k = 0; k < 4; k++) drive_period(p, h, d0, d1, d2, d3, d4);
        drive_period(p, h, mv_at, pa, ha, lk, ns);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk_50);
        rst = 1'b0;
    endtask

`ifdef PHASE_MEAS_EN
    task automatic phase_trial(input int lead, input int early, output int ph);
        int n;
        n = (early > lead) ? early : lead;
        for (int t = n; t >= -8; t--) begin
            mif.ref_in = (t == lead) || ((early > lead) && (t == early));
            mif.sig_in = (t <= 0) && (t > -4);
            @(negedge clk_50);
        end
        ph = int'(mif.phase_cyc);
    endtask
`endif

    initial begin
        int mv_at, pa, ha, lk, ns, bad, mv0, ns_pre, lk_pre, d0, d1, d2, d3, d4;
`ifdef PHASE_MEAS_EN
        int ph;
`endif
        rst = 1'b1;
        mif.sig_in = 1'b0;
`ifdef PHASE_MEAS_EN
        mif.ref_in = 1'b0;
`endif
        repeat (3) @(negedge clk_50);
        check_val("rst_period_avg", int'(mif.period_avg), 0);
        check_val("rst_high_avg", int'(mif.high_avg), 0);
        check_val("rst_meas_valid", int'(mif.meas_valid), 0);
        check_val("rst_locked", int'(mif.locked), 0);
        check_val("rst_nosig", int'(mif.nosig), 1);
        rst = 1'b0;

        // Constant-low input: never valid, never locked.
        bad = 0;
        mv0 = mv_total;
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk_50);
            if (!mif.nosig || mif.locked || mif.meas_valid) bad++;
        end
        check_val("idle_flag_errors", bad, 0);
        check_val("idle_pulses", mv_total - mv0, 0);

        // 400/200 wave, 5 rises -> one result 4 cycles after the 5th rise.
        mv0 = mv_total;
        lock_up(400, 200, mv_at, pa, ha, lk, ns);
        check_val("w400_latency", mv_at, 4);
        check_val("w400_period", pa, 400);
        check_val("w400_high", ha, 200);
        check_val("w400_locked", lk, 1);
        check_val("w400_nosig", ns, 0);
        check_val("w400_pulses", mv_total - mv0, 1);

        // Periods 400,401,401,401 -> 1603>>2 = 400; then steady 401 -> results 1604 apart.
        pulse_rst();
        drive_period(400, 200, d0, d1, d2, d3, d4);
        for (int k = 0; k < 3; k++) drive_period(401, 200, d0, d1, d2, d3, d4);
        drive_period(401, 200, mv_at, pa, ha, lk, ns);
        check_val("mix_latency", mv_at, 4);
        check_val("mix_period_trunc", pa, 400);
        check_val("mix_high", ha, 200);
        for (int k = 0; k < 3; k++) drive_period(401, 200, d0, d1, d2, d3, d4);
        drive_period(401, 200, mv_at, pa, ha, lk, ns);
        check_val("w401_period", pa, 401);
        check_val("w401_spacing", mv_last - mv_prev, 1604);

        // Lock at 400, then stick high: timeout 2000 cycles after the last detected rise.
        pulse_rst();
        lock_up(400, 200, mv_at, pa, ha, lk, ns);
        check_val("pre_stuck_locked", lk, 1);
        mif.sig_in = 1'b1;
        ns_pre = -1;
        lk_pre = -1;
        for (int k = 1; k <= 2003; k++) begin
            @(negedge clk_50);
            if (k == 2002) begin
                ns_pre = int'(mif.nosig);
                lk_pre = int'(mif.locked);
            end
        end
        check_val("stuck_nosig_early", ns_pre, 0);
        check_val("stuck_locked_early", lk_pre, 1);
        check_val("stuck_nosig", int'(mif.nosig), 1);
        check_val("stuck_locked", int'(mif.locked), 0);
        check_val("stuck_period_hold", int'(mif.period_avg), 400);
        check_val("stuck_high_hold", int'(mif.high_avg), 200);
        mif.sig_in = 1'b0;
        repeat (100) @(negedge clk_50);
        mv0 = mv_total;
        lock_up(400, 200, mv_at, pa, ha, lk, ns);
        check_val("resume_latency", mv_at, 4);
        check_val("resume_nosig", ns, 0);
        check_val("resume_locked", lk, 1);
        check_val("resume_pulses", mv_total - mv0, 1);

        // Reset in the low phase of the 3rd period of an average.
        drive_period(400, 200, d0, d1, d2, d3, d4);
        drive_period(400, 200, d0, d1, d2, d3, d4);
        for (int i = 0; i < 300; i++) begin
            mif.sig_in = (i < 200);
            @(negedge clk_50);
        end
        rst = 1'b1;
        @(negedge clk_50);
        check_val("mid_rst_period", int'(mif.period_avg), 0);
        check_val("mid_rst_high", int'(mif.high_avg), 0);
        check_val("mid_rst_locked", int'(mif.locked), 0);
        check_val("mid_rst_nosig", int'(mif.nosig), 1);
        rst = 1'b0;
        repeat (100) @(negedge clk_50);
        mv0 = mv_total;
        lock_up(300, 100, mv_at, pa, ha, lk, ns);
        check_val("post_rst_latency", mv_at, 4);
        check_val("post_rst_period", pa, 300);
        check_val("post_rst_high", ha, 100);
        check_val("post_rst_pulses", mv_total - mv0, 1);

        // 1-sample glitch each 20 cycles counts as a period.
        pulse_rst();
        lock_up(20, 1, mv_at, pa, ha, lk, ns);
        check_val("glitch_latency", mv_at, 4);
        check_val("glitch_period", pa, 20);
        check_val("glitch_high", ha, 1);

`ifdef PHASE_MEAS_EN
        pulse_rst();
        check_val("phase_rst", int'(mif.phase_cyc), 0);
        phase_trial(37, -1, ph);
        check_val("phase_37", ph, 37);
        phase_trial(0, -1, ph);
        check_val("phase_simul", ph, 0);
        phase_trial(37, 60, ph);
        check_val("phase_rearm", ph, 37);
        phase_trial(25, -1, ph);
        check_val("phase_25", ph, 25);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
